// File: rtl/pellet_grid_ctrl.sv
// pellet_grid_ctrl: ROWS x COLS store of 2-bit pellet cell codes for the maze.
//
// After reset or refill an init sweep copies the map ROM into the grid, one cell
// per clock in row-major order, and counts the pellets. In RUN, each frame_tick
// collects the pellet under Pac-Man and emits a one-clock scoring pulse. When
// the last pellet goes, the block parks in CLEARED with the level-clear flag held.
//
// Ports
//   clk_i                  system clock
//   reset_i                asynchronous, active-high reset
//   frame_tick_i           one-clock collection strobe per game frame
//   refill_i               one-clock pulse, reload the grid for a new level
//   pacman_row_i/col_i     Pac-Man tile
//   read_row_i/col_i       renderer read address
//   init_row_o/col_o       map ROM address during the sweep
//   init_cell_i            map ROM data, combinational for the current address
//   pellet_data_o          cell code at the read address (0 empty, 1 pellet, 2 power)
//   init_busy_o            high while the sweep runs
//   pellet_collected_o     one-clock pulse, regular pellet eaten
//   power_collected_o      one-clock pulse, power pellet eaten
//   score_delta_o          points for this collection, 0 otherwise
//   pellets_remaining_o    uncollected pellets of both types
//   all_pellets_cleared_o  level-clear flag, held until refill or reset
module pellet_grid_ctrl #(
    parameter int unsigned ROWS          = 31,
    parameter int unsigned COLS          = 28,
    parameter int unsigned PELLET_POINTS = 10,
    parameter int unsigned POWER_POINTS  = 50,
    parameter int unsigned SCORE_W       = 8,
    localparam int unsigned ROW_W = $clog2(ROWS),
    localparam int unsigned COL_W = $clog2(COLS),
    localparam int unsigned CNT_W = $clog2(ROWS * COLS + 1)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               frame_tick_i,
    input  logic               refill_i,
    input  logic [ROW_W-1:0]   pacman_row_i,
    input  logic [COL_W-1:0]   pacman_col_i,
    input  logic [ROW_W-1:0]   read_row_i,
    input  logic [COL_W-1:0]   read_col_i,
    output logic [ROW_W-1:0]   init_row_o,
    output logic [COL_W-1:0]   init_col_o,
    input  logic [1:0]         init_cell_i,
    output logic [1:0]         pellet_data_o,
    output logic               init_busy_o,
    output logic               pellet_collected_o,
    output logic               power_collected_o,
    output logic [SCORE_W-1:0] score_delta_o,
    output logic [CNT_W-1:0]   pellets_remaining_o,
    output logic               all_pellets_cleared_o
);

    typedef enum logic [1:0] {StInit, StRun, StCleared} state_e;

    state_e             state_q;
    logic [ROW_W-1:0]   row_q;
    logic [COL_W-1:0]   col_q;
    logic [CNT_W-1:0]   remaining_q;
    logic               cleared_q;
    logic               pellet_q;
    logic               power_q;
    logic [SCORE_W-1:0] score_q;

    // Grid contents are not reset; every sweep rewrites all cells.
    logic [1:0] grid_q [ROWS][COLS];

    logic             pac_in_range;
    logic [ROW_W-1:0] pac_row_idx;
    logic [COL_W-1:0] pac_col_idx;
    logic [1:0]       pac_cell;
    logic             rd_in_range;
    logic [ROW_W-1:0] rd_row_idx;
    logic [COL_W-1:0] rd_col_idx;
    logic [1:0]       init_code;
    logic             init_last;
    logic             collect;
    logic [CNT_W-1:0] init_count;

    always_comb begin
        pac_in_range = (32'(pacman_row_i) < ROWS) && (32'(pacman_col_i) < COLS);
        // Clamp indices so out-of-range coordinates never address past the array.
        pac_row_idx  = pac_in_range ? pacman_row_i : '0;
        pac_col_idx  = pac_in_range ? pacman_col_i : '0;
        pac_cell     = grid_q[pac_row_idx][pac_col_idx];

        rd_in_range  = (32'(read_row_i) < ROWS) && (32'(read_col_i) < COLS);
        rd_row_idx   = rd_in_range ? read_row_i : '0;
        rd_col_idx   = rd_in_range ? read_col_i : '0;

        // Code 3 is reserved and stored as empty.
        init_code    = (init_cell_i == 2'd3) ? 2'd0 : init_cell_i;
        init_last    = (32'(row_q) == ROWS - 1) && (32'(col_q) == COLS - 1);
        init_count   = remaining_q + CNT_W'(init_code != 2'd0);

        collect      = (state_q == StRun) && frame_tick_i && !refill_i && pac_in_range &&
                       (pac_cell != 2'd0) && (remaining_q != '0);
    end

    always_ff @(posedge clk_i) begin
        if (state_q == StInit && !refill_i) begin
            grid_q[row_q][col_q] <= init_code;
        end else if (collect) begin
            grid_q[pac_row_idx][pac_col_idx] <= 2'd0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= StInit;
            row_q       <= '0;
            col_q       <= '0;
            remaining_q <= '0;
            cleared_q   <= 1'b0;
            pellet_q    <= 1'b0;
            power_q     <= 1'b0;
            score_q     <= '0;
        end else begin
            pellet_q <= 1'b0;
            power_q  <= 1'b0;
            score_q  <= '0;
            if (refill_i) begin
                state_q     <= StInit;
                row_q       <= '0;
                col_q       <= '0;
                remaining_q <= '0;
                cleared_q   <= 1'b0;
            end else begin
                unique case (state_q)
                    StInit: begin
                        remaining_q <= init_count;
                        if (init_last) begin
                            row_q <= '0;
                            col_q <= '0;
                            if (init_count == '0) begin
                                state_q   <= StCleared;
                                cleared_q <= 1'b1;
                            end else begin
                                state_q <= StRun;
                            end
                        end else if (32'(col_q) == COLS - 1) begin
                            col_q <= '0;
                            row_q <= row_q + ROW_W'(1);
                        end else begin
                            col_q <= col_q + COL_W'(1);
                        end
                    end
                    StRun: begin
                        if (collect) begin
                            remaining_q <= remaining_q - CNT_W'(1);
                            if (pac_cell == 2'd2) begin
                                power_q <= 1'b1;
                                score_q <= SCORE_W'(POWER_POINTS);
                            end else begin
                                pellet_q <= 1'b1;
                                score_q  <= SCORE_W'(PELLET_POINTS);
                            end
                            if (remaining_q == CNT_W'(1)) begin
                                state_q   <= StCleared;
                                cleared_q <= 1'b1;
                            end
                        end
                    end
                    StCleared: begin
                        cleared_q <= 1'b1;
                    end
                    default: begin
                        state_q <= StInit;
                    end
                endcase
            end
        end
    end

    always_comb begin
        init_row_o            = row_q;
        init_col_o            = col_q;
        init_busy_o           = (state_q == StInit);
        pellet_data_o         = (rd_in_range && !init_busy_o) ?
                                grid_q[rd_row_idx][rd_col_idx] : 2'd0;
        pellet_collected_o    = pellet_q;
        power_collected_o     = power_q;
        score_delta_o         = score_q;
        pellets_remaining_o   = remaining_q;
        all_pellets_cleared_o = cleared_q;
    end

endmodule

// File: tb/tb_pellet_grid_ctrl.sv
// Directed bench for pellet_grid_ctrl on a 3x4 map with 5 pellets, 1 power
// pellet and one reserved code-3 cell.
module tb_pellet_grid_ctrl;

    localparam int unsigned ROWS = 3;
    localparam int unsigned COLS = 4;

    logic       clk;
    logic       reset;
    logic       frame_tick;
    logic       refill;
    logic [1:0] pacman_row;
    logic [1:0] pacman_col;
    logic [1:0] read_row;
    logic [1:0] read_col;
    logic [1:0] init_row;
    logic [1:0] init_col;
    logic [1:0] init_cell;
    logic [1:0] pellet_data;
    logic       init_busy;
    logic       pellet_collected;
    logic       power_collected;
    logic [7:0] score_delta;
    logic [3:0] pellets_remaining;
    logic       all_pellets_cleared;

    logic [1:0] map_mem [16];

    int tests_run;
    int tests_failed;

    assign init_cell = map_mem[{init_row, init_col}];

    pellet_grid_ctrl #(
        .ROWS(ROWS),
        .COLS(COLS),
        .PELLET_POINTS(10),
        .POWER_POINTS(50),
        .SCORE_W(8)
    ) u_dut (
        .clk_i                (clk),
        .reset_i              (reset),
        .frame_tick_i         (frame_tick),
        .refill_i             (refill),
        .pacman_row_i         (pacman_row),
        .pacman_col_i         (pacman_col),
        .read_row_i           (read_row),
        .read_col_i           (read_col),
        .init_row_o           (init_row),
        .init_col_o           (init_col),
        .init_cell_i          (init_cell),
        .pellet_data_o        (pellet_data),
        .init_busy_o          (init_busy),
        .pellet_collected_o   (pellet_collected),
        .power_collected_o    (power_collected),
        .score_delta_o        (score_delta),
        .pellets_remaining_o  (pellets_remaining),
        .all_pellets_cleared_o(all_pellets_cleared)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d required %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts clocks until init_busy falls, bounded.
    task automatic wait_sweep(input string tag);
        int n;
        n = 0;
        while (init_busy && n < 100) begin
            step();
            n++;
        end
        check_eq(tag, n, 12);
    endtask

    // One frame_tick on a tile; checks the registered pulse and that it lasts one clock.
    task automatic eat(input string tag, input logic [1:0] r, input logic [1:0] c,
                       input logic exp_pel, input logic exp_pow, input int exp_score,
                       input int exp_rem, input logic exp_clr);
        pacman_row = r;
        pacman_col = c;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        check_eq({tag, " pellet"}, pellet_collected, exp_pel);
        check_eq({tag, " power"}, power_collected, exp_pow);
        check_eq({tag, " score"}, score_delta, exp_score);
        check_eq({tag, " remaining"}, pellets_remaining, exp_rem);
        check_eq({tag, " cleared"}, all_pellets_cleared, exp_clr);
        step();
        check_eq({tag, " pulse len"}, {pellet_collected, power_collected}, 0);
        check_eq({tag, " score len"}, score_delta, 0);
    endtask

    task automatic check_read(input string tag, input logic [1:0] r, input logic [1:0] c,
                              input logic [1:0] exp);
        read_row = r;
        read_col = c;
        #1;
        check_eq(tag, pellet_data, exp);
    endtask

    initial begin
        logic [1:0] m;
        tests_run    = 0;
        tests_failed = 0;
        for (int i = 0; i < 16; i++) map_mem[i] = 2'd0;
        // row 0: 1 0 2 1 / row 1: 0 3 1 0 / row 2: 1 0 0 1
        map_mem[0]  = 2'd1;
        map_mem[2]  = 2'd2;
        map_mem[3]  = 2'd1;
        map_mem[5]  = 2'd3;
        map_mem[6]  = 2'd1;
        map_mem[8]  = 2'd1;
        map_mem[11] = 2'd1;

        reset      = 1'b1;
        frame_tick = 1'b0;
        refill     = 1'b0;
        pacman_row = 2'd0;
        pacman_col = 2'd0;
        read_row   = 2'd0;
        read_col   = 2'd0;
        repeat (2) step();

        check_eq("rst busy", init_busy, 1);
        check_eq("rst remaining", pellets_remaining, 0);
        check_eq("rst cleared", all_pellets_cleared, 0);
        check_eq("rst pulses", {pellet_collected, power_collected}, 0);
        check_eq("rst score", score_delta, 0);
        check_eq("rst addr", {init_row, init_col}, 0);

        reset = 1'b0;
        wait_sweep("sweep1 length");
        check_eq("sweep1 remaining", pellets_remaining, 6);
        check_eq("sweep1 cleared", all_pellets_cleared, 0);
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 4; c++) begin
                m = map_mem[r * 4 + c];
                check_read($sformatf("read r%0d c%0d", r, c), 2'(r), 2'(c),
                           (m == 2'd3) ? 2'd0 : m);
            end
        end
        check_read("read oob row", 2'd3, 2'd0, 2'd0);

        // Regular pellet, then the same tile again.
        eat("eat00", 2'd0, 2'd0, 1'b1, 1'b0, 10, 5, 1'b0);
        check_read("read 00 after eat", 2'd0, 2'd0, 2'd0);
        eat("eat00 again", 2'd0, 2'd0, 1'b0, 1'b0, 0, 5, 1'b0);
        // Power pellet.
        eat("eat02 power", 2'd0, 2'd2, 1'b0, 1'b1, 50, 4, 1'b0);
        // Out-of-range row (tunnel).
        eat("oob row", 2'd3, 2'd3, 1'b0, 1'b0, 0, 4, 1'b0);

        // Refill coincident with frame_tick on pellet tile (0,3).
        pacman_row = 2'd0;
        pacman_col = 2'd3;
        frame_tick = 1'b1;
        refill     = 1'b1;
        step();
        frame_tick = 1'b0;
        refill     = 1'b0;
        check_eq("refill pulse", {pellet_collected, power_collected}, 0);
        check_eq("refill score", score_delta, 0);
        check_eq("refill busy", init_busy, 1);
        check_eq("refill remaining", pellets_remaining, 0);
        wait_sweep("sweep2 length");
        check_eq("sweep2 remaining", pellets_remaining, 6);
        check_read("reload 00", 2'd0, 2'd0, 2'd1);
        check_read("reload 02", 2'd0, 2'd2, 2'd2);
        check_read("kept 03", 2'd0, 2'd3, 2'd1);

        // Eat everything; the last one is the power pellet.
        eat("all 00", 2'd0, 2'd0, 1'b1, 1'b0, 10, 5, 1'b0);
        eat("all 03", 2'd0, 2'd3, 1'b1, 1'b0, 10, 4, 1'b0);
        eat("all 12", 2'd1, 2'd2, 1'b1, 1'b0, 10, 3, 1'b0);
        eat("all 20", 2'd2, 2'd0, 1'b1, 1'b0, 10, 2, 1'b0);
        eat("all 23", 2'd2, 2'd3, 1'b1, 1'b0, 10, 1, 1'b0);
        eat("all 02", 2'd0, 2'd2, 1'b0, 1'b1, 50, 0, 1'b1);
        eat("cleared tick", 2'd0, 2'd0, 1'b0, 1'b0, 0, 0, 1'b1);

        // Refill out of CLEARED, then reset in the middle of the sweep.
        refill = 1'b1;
        step();
        refill = 1'b0;
        check_eq("refill2 cleared", all_pellets_cleared, 0);
        check_eq("refill2 busy", init_busy, 1);
        repeat (7) step();
        check_eq("mid addr", {init_row, init_col}, {2'd1, 2'd3});
        check_eq("mid remaining", pellets_remaining, 4);
        check_read("mid read masked", 2'd0, 2'd0, 2'd0);
        #1;
        reset = 1'b1;
        #1;
        check_eq("async addr", {init_row, init_col}, 0);
        check_eq("async remaining", pellets_remaining, 0);
        check_eq("async busy", init_busy, 1);
        step();
        reset = 1'b0;
        wait_sweep("sweep3 length");
        check_eq("sweep3 remaining", pellets_remaining, 6);
        check_read("code3 reads 0", 2'd1, 2'd1, 2'd0);
        check_read("sweep3 read 02", 2'd0, 2'd2, 2'd2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
